// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART tx line between NUM_REQ byte producers.
// Frames are start, DATA_BITS data LSB-first, STOP_BITS stop; all bit timing from tx_tick.
//
// state | meaning
// IDLE  | line idle high, waiting for a tick with any req set
// START | start bit (low) on the line
// DATA  | data bits on the line, LSB first
// STOP  | stop bit(s) high; final stop tick may chain straight into the next grant
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           tx_tick,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   din,
    output logic [NUM_REQ-1:0]             ack,
    output logic [$clog2(NUM_REQ)-1:0]     owner,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           tx
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                 state;
    logic [DATA_BITS-1:0]   shift;
    logic [BW-1:0]          bit_cnt;
    logic                   stop_cnt;
    logic [IW-1:0]          last_grant;

    logic [DATA_BITS-1:0]   din_arr [NUM_REQ];
    logic                   grant_valid;
    logic [IW-1:0]          grant_idx;
    logic [IW-1:0]          cand;
    logic                   do_grant;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_din
        assign din_arr[i] = din[i*DATA_BITS +: DATA_BITS];
    end

    // Search from last_grant+1 upward with wrap; scanning far-to-near lets the nearest win.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign do_grant = tx_tick && grant_valid &&
                      ((state == IDLE) || (state == STOP && stop_cnt == 1'b0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            busy       <= 1'b0;
            ack        <= '0;
            frame_done <= 1'b0;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            shift      <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            ack        <= '0;
            frame_done <= 1'b0;
            if (tx_tick && state == STOP && stop_cnt == 1'b0)
                frame_done <= 1'b1;
            if (do_grant) begin
                ack        <= NUM_REQ'(1) << grant_idx;
                shift      <= din_arr[grant_idx];
                owner      <= grant_idx;
                last_grant <= grant_idx;
                tx         <= 1'b0;
                busy       <= 1'b1;
                state      <= START;
            end else if (tx_tick) begin
                case (state)
                    IDLE: ;
                    START: begin
                        tx      <= shift[0];
                        shift   <= shift >> 1;
                        bit_cnt <= BW'(DATA_BITS - 1);
                        state   <= DATA;
                    end
                    DATA: begin
                        if (bit_cnt == '0) begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'(STOP_BITS - 1);
                            state    <= STOP;
                        end else begin
                            tx      <= shift[0];
                            shift   <= shift >> 1;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end
                    STOP: begin
                        if (stop_cnt == 1'b0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt - 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a line monitor decodes frames off tx and
// pops per-requester expected bytes and an expected grant order from scoreboard queues.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DB  = 8;
    localparam int SB  = 1;
    localparam int DB2 = 7;
    localparam int SB2 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_tick = 1'b0;

    logic [N-1:0]    req = '0;
    logic [N*DB-1:0] din = '0;
    logic [N-1:0]    ack;
    logic [1:0]      owner;
    logic            busy, frame_done, tx;

    logic [N-1:0]     req2 = '0;
    logic [N*DB2-1:0] din2 = '0;
    logic [N-1:0]     ack2;
    logic [1:0]       owner2;
    logic             busy2, frame_done2, tx2;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .req(req), .din(din),
        .ack(ack), .owner(owner), .busy(busy), .frame_done(frame_done), .tx(tx));

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB2), .STOP_BITS(SB2)) dut2 (
        .clk(clk), .rst(rst), .tx_tick(tx_tick), .req(req2), .din(din2),
        .ack(ack2), .owner(owner2), .busy(busy2), .frame_done(frame_done2), .tx(tx2));

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // one-clk tick every 4 clk, driven away from the active edge
    int tick_div = 0;
    always @(negedge clk) begin
        tick_div = (tick_div + 1) % 4;
        tx_tick  = (tick_div == 0);
    end

    logic tick_at_edge = 1'b0;
    always @(posedge clk) tick_at_edge <= tx_tick;

    // scoreboard
    logic [DB-1:0] expd [N][$];
    int            exp_own[$];
    int            ackq[$];
    int            gaps[$];
    int            cnt[N];

    // line monitor state
    bit            mon_en = 1'b0;
    int            mon_state = 0;
    int            bit_i = 0;
    int            stop_i = 0;
    int            gap = 0;
    int            frames_done = 0;
    logic [DB-1:0] shreg = '0;
    logic          tx_prev = 1'b1;
    int            ack2_cnt = 0;

    always @(negedge clk) if (ack2 !== '0) ack2_cnt++;

    always @(negedge clk) begin
        logic          fd_exp;
        int            a_idx;
        int            o_obs;
        int            o_exp;
        logic [DB-1:0] d_exp;
        if (mon_en) begin
            fd_exp = tick_at_edge && (mon_state == 3);
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL frame_done_timing: got %b expected %b at %0t", frame_done, fd_exp, $time);
            end
            if (!tick_at_edge) begin
                checks++;
                if (tx !== tx_prev) begin
                    errors++;
                    $display("FAIL tx_hold: got %b expected %b between ticks at %0t", tx, tx_prev, $time);
                end
            end
            if (ack !== '0) begin
                a_idx = -1;
                for (int i = 0; i < N; i++) if (ack[i]) a_idx = i;
                checks++;
                if (!tick_at_edge || $countones(ack) != 1 || int'(owner) != a_idx) begin
                    errors++;
                    $display("FAIL ack_owner: ack=%b owner=%0d tick=%b expected one-hot ack matching owner on a tick",
                             ack, owner, tick_at_edge);
                end
                ackq.push_back(a_idx);
            end
            if (tick_at_edge) begin
                case (mon_state)
                    0: begin
                        if (tx === 1'b0) begin
                            checks++;
                            if (busy !== 1'b1) begin
                                errors++;
                                $display("FAIL busy_start: got %b expected 1", busy);
                            end
                            gaps.push_back(gap);
                            bit_i = 0;
                            mon_state = 1;
                        end else begin
                            gap++;
                        end
                    end
                    1: begin
                        shreg = {tx, shreg[DB-1:1]};
                        bit_i++;
                        if (bit_i == DB) begin
                            mon_state = 2;
                            stop_i = 0;
                        end
                    end
                    2: begin
                        checks++;
                        if (tx !== 1'b1) begin
                            errors++;
                            $display("FAIL stop_bit: got %b expected 1", tx);
                        end
                        stop_i++;
                        if (stop_i == SB) begin
                            frames_done++;
                            checks++;
                            if (ackq.size() == 0 || exp_own.size() == 0) begin
                                errors++;
                                $display("FAIL frame_unexpected: got byte %h with acks=%0d expected=%0d",
                                         shreg, ackq.size(), exp_own.size());
                            end else begin
                                o_obs = ackq.pop_front();
                                o_exp = exp_own.pop_front();
                                if (o_obs != o_exp || o_obs < 0 || expd[o_obs].size() == 0) begin
                                    errors++;
                                    $display("FAIL frame_owner: got %0d expected %0d", o_obs, o_exp);
                                end else begin
                                    d_exp = expd[o_obs].pop_front();
                                    checks++;
                                    if (shreg !== d_exp) begin
                                        errors++;
                                        $display("FAIL frame_data: got %h expected %h (owner %0d)", shreg, d_exp, o_obs);
                                    end
                                end
                            end
                            mon_state = 3;
                        end
                    end
                    default: begin
                        checks++;
                        if (tx === 1'b0) begin
                            if (busy !== 1'b1 || ack === '0) begin
                                errors++;
                                $display("FAIL back_to_back: busy=%b ack=%b expected busy=1 and an ack", busy, ack);
                            end
                            gaps.push_back(0);
                            bit_i = 0;
                            mon_state = 1;
                        end else begin
                            if (busy !== 1'b0) begin
                                errors++;
                                $display("FAIL busy_fall: got %b expected 0", busy);
                            end
                            gap = 1;
                            mon_state = 0;
                        end
                    end
                endcase
            end
        end
        tx_prev = tx;
    end

    task automatic wait_tick_neg();
        int n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (tx_tick !== 1'b1 && n < 20);
        if (tx_tick !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: got no tick expected one within 20 clk");
        end
        @(negedge clk);
    endtask

    task automatic wait_ack(output int idx);
        int n = 0;
        idx = -1;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (ack !== '0) begin
                for (int i = 0; i < N; i++) if (ack[i]) idx = i;
                break;
            end
        end
        if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack expected one within 400 clk");
        end
    endtask

    task automatic wait_frames(input int n);
        int c = 0;
        while (frames_done < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (frames_done < n) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, n);
        end
    endtask

    task automatic present(input int r);
        logic [DB-1:0] v;
        v = 8'(r * 37 + cnt[r] * 11 + 5);
        cnt[r]++;
        din[r*DB +: DB] = v;
        expd[r].push_back(v);
    endtask

    task automatic do_reset();
        mon_en = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({tx, busy, ack, frame_done, owner} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_values: got tx=%b busy=%b ack=%b fd=%b owner=%0d expected 1 0 0000 0 0",
                     tx, busy, ack, frame_done, owner);
        end
        checks++;
        if ({tx2, busy2, ack2, frame_done2, owner2} !== {1'b1, 1'b0, 4'b0000, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL reset_values2: got tx=%b busy=%b ack=%b fd=%b owner=%0d expected 1 0 0000 0 0",
                     tx2, busy2, ack2, frame_done2, owner2);
        end
        req = '0;
        req2 = '0;
        ackq.delete();
        exp_own.delete();
        gaps.delete();
        for (int i = 0; i < N; i++) begin
            expd[i].delete();
            cnt[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_state = 0;
        gap = 0;
        frames_done = 0;
        ack2_cnt = 0;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        repeat (12) @(negedge clk);
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got tx=%b busy=%b expected 1 0", tx, busy);
        end
    endtask

    task automatic test_single_frame();
        do_reset();
        @(negedge clk);
        din[7:0] = 8'hA5;
        req[0] = 1'b1;
        expd[0].push_back(8'hA5);
        exp_own.push_back(0);
        wait_tick_neg();
        checks++;
        if (ack !== 4'b0001 || tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got ack=%b tx=%b busy=%b expected 0001 0 1", ack, tx, busy);
        end
        req[0] = 1'b0;
        for (int t = 1; t <= 9; t++) wait_tick_neg();
        checks++;
        if (busy !== 1'b1 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL single_tick9: got busy=%b fd=%b expected 1 0", busy, frame_done);
        end
        wait_tick_neg();
        checks++;
        if (frame_done !== 1'b1 || busy !== 1'b0 || tx !== 1'b1) begin
            errors++;
            $display("FAIL single_end: got fd=%b busy=%b tx=%b expected 1 0 1", frame_done, busy, tx);
        end
        wait_frames(1);
    endtask

    task automatic test_back_to_back();
        int idx;
        do_reset();
        @(negedge clk);
        din = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < N; i++) begin
            expd[i].push_back(8'(8'h11 * (i + 1)));
            exp_own.push_back(i);
        end
        req = 4'b1111;
        for (int s = 0; s < N; s++) begin
            wait_ack(idx);
            checks++;
            if (idx != s) begin
                errors++;
                $display("FAIL b2b_order: got %0d expected %0d", idx, s);
            end
            if (idx >= 0) req[idx] = 1'b0;
        end
        wait_frames(4);
        wait_tick_neg();
        checks++;
        if (gaps.size() != 4) begin
            errors++;
            $display("FAIL b2b_frames: got %0d frame starts expected 4", gaps.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (gaps[i] != 0) begin
                    errors++;
                    $display("FAIL b2b_gap: got %0d idle bits before frame %0d expected 0", gaps[i], i);
                end
            end
        end
    endtask

    task automatic test_fairness();
        int idx;
        int plan[6] = '{0, 2, 0, 1, 2, 0};
        bit more;
        do_reset();
        @(negedge clk);
        foreach (plan[p]) exp_own.push_back(plan[p]);
        present(0);
        present(2);
        req[0] = 1'b1;
        req[2] = 1'b1;
        for (int s = 0; s < 6; s++) begin
            wait_ack(idx);
            checks++;
            if (idx != plan[s]) begin
                errors++;
                $display("FAIL fair_order: step %0d got %0d expected %0d", s, idx, plan[s]);
            end
            if (idx < 0) break;
            more = 1'b0;
            for (int j = s + 1; j < 6; j++) if (plan[j] == idx) more = 1'b1;
            if (more) present(idx);
            else req[idx] = 1'b0;
            if (s == 2) begin
                present(1);
                req[1] = 1'b1;
            end
        end
        req = '0;
        wait_frames(6);
        wait_tick_neg();
    endtask

    task automatic test_reset_midframe();
        int idx;
        do_reset();
        @(negedge clk);
        din[1*DB +: DB] = 8'hC3;
        req[1] = 1'b1;
        wait_ack(idx);
        req[1] = 1'b0;
        checks++;
        if (idx != 1) begin
            errors++;
            $display("FAIL abort_grant: got %0d expected 1", idx);
        end
        repeat (4) wait_tick_neg();
        checks++;
        if (tx !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_bit3: got tx=%b busy=%b expected 0 1", tx, busy);
        end
        do_reset();
        @(negedge clk);
        present(1);
        present(3);
        exp_own.push_back(1);
        exp_own.push_back(3);
        req[1] = 1'b1;
        req[3] = 1'b1;
        wait_ack(idx);
        checks++;
        if (idx != 1) begin
            errors++;
            $display("FAIL abort_rr_first: got %0d expected 1", idx);
        end
        if (idx >= 0) req[idx] = 1'b0;
        wait_ack(idx);
        checks++;
        if (idx != 3) begin
            errors++;
            $display("FAIL abort_rr_second: got %0d expected 3", idx);
        end
        req = '0;
        wait_frames(2);
        wait_tick_neg();
    endtask

    task automatic test_stop2();
        logic [DB2-1:0] v;
        logic           bitq[$];
        logic           e;
        do_reset();
        wait_tick_neg();
        din2[DB2-1:0] = 7'h2A;
        req2[0] = 1'b1;
        @(negedge clk);
        req2[0] = 1'b0;
        repeat (3) wait_tick_neg();
        checks++;
        if (ack2_cnt != 0 || busy2 !== 1'b0 || tx2 !== 1'b1) begin
            errors++;
            $display("FAIL glitch_req: got acks=%0d busy=%b tx=%b expected 0 0 1", ack2_cnt, busy2, tx2);
        end
        @(negedge clk);
        v = 7'h4B;
        din2[DB2-1:0] = v;
        req2[0] = 1'b1;
        bitq.push_back(1'b0);
        for (int i = 0; i < DB2; i++) bitq.push_back(v[i]);
        for (int i = 0; i < SB2; i++) bitq.push_back(1'b1);
        wait_tick_neg();
        checks++;
        if (ack2 !== 4'b0001) begin
            errors++;
            $display("FAIL stop2_grant: got ack=%b expected 0001", ack2);
        end
        req2[0] = 1'b0;
        for (int p = 0; p < 1 + DB2 + SB2; p++) begin
            if (p > 0) wait_tick_neg();
            e = bitq.pop_front();
            checks++;
            if (tx2 !== e || busy2 !== 1'b1 || frame_done2 !== 1'b0) begin
                errors++;
                $display("FAIL stop2_bit: period %0d got tx=%b busy=%b fd=%b expected tx=%b busy=1 fd=0",
                         p, tx2, busy2, frame_done2, e);
            end
        end
        wait_tick_neg();
        checks++;
        if (frame_done2 !== 1'b1 || busy2 !== 1'b0 || tx2 !== 1'b1 || ack2_cnt != 1) begin
            errors++;
            $display("FAIL stop2_end: got fd=%b busy=%b tx=%b acks=%0d expected 1 0 1 1",
                     frame_done2, busy2, tx2, ack2_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fairness();
        test_reset_midframe();
        test_stop2();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected end of tests");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin scheduler that shares one UART transmit line between NUM_REQ byte producers. It frames each granted byte as start, data LSB-first, then stop, and serializes it on tx. Bit timing comes only from the single-cycle tx_tick enable driven by the baud_gen tx_clk output. It sits between the producer blocks and the UART pin, in the clk domain of baud_gen.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, data bits per frame (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tx_tick  input  1  one-clk-wide baud enable from baud_gen tx_clk
req  input  NUM_REQ  per-requester send request (level)
din  input  NUM_REQ*DATA_BITS  requester i byte at din[i*DATA_BITS +: DATA_BITS]
ack  output  NUM_REQ  one-cycle pulse: byte of requester i latched
owner  output  clog2(NUM_REQ)  index of the current/last granted requester
busy  output  1  high while a frame is on the line
frame_done  output  1  one-cycle pulse on the tick that ends the last stop bit
tx  output  1  serial line, idle high

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high. All outputs are registered.
- Reset values: tx=1, busy=0, ack=0, frame_done=0, owner=0, state=IDLE, rr pointer=NUM_REQ-1 (requester 0 has highest priority first).
- States: IDLE, START, DATA, STOP. All state advances happen only in cycles where tx_tick=1. Between ticks, state and tx hold.
- IDLE: when tx_tick=1 and |req, grant the first requester with req set, searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - In that cycle: ack[g]=1; shift register <= din[g]; owner<=g; last_grant<=g; state->START.
  - From the next cycle: tx=0 and busy=1.
  - req with no tick: no grant.
- START: on tick, go to DATA with bit index 0; tx=shift[0] from the next cycle.
- DATA: each tick shifts right (LSB first) and increments the index. On the tick after bit DATA_BITS-1, go to STOP; tx=1.
- STOP: held for STOP_BITS tick periods. On the final stop tick:
  - frame_done=1 for one cycle.
  - If any req is set in that same cycle, the next grant happens immediately (ack, latch, START). Frames run back-to-back with no idle bit, busy stays 1, and tx=0 the next cycle.
  - Otherwise state=IDLE and busy=0 the next cycle.
- Every bit lasts exactly one tick period. A frame is 1+DATA_BITS+STOP_BITS tick periods.
- Handshake: the requester holds req with din stable until it sees ack. It may drop req, or present a new byte with req still high, on the cycle after ack. Dropping req before ack withdraws the request with no side effects. req during a frame is ignored until the frame-end tick. ack never pulses for a requester whose req is low.
- Exactly one ack bit is high at most, and only in a tick cycle.
- Reset mid-frame aborts immediately: tx=1, busy=0, rr pointer restored. The aborted byte is lost and is not re-acked.
- Unused high din bits are not applicable; din width is exact.

Test Plan:
- Reset: assert rst at arbitrary times, including mid-cycle -> tx=1, busy=0, ack=0, owner=0, frame_done=0 with no clk edge needed.
- Single frame, tx_tick every 4 clk: req[0]=1, din0=8'hA5.
  - ack[0] pulses on the first tick.
  - tx per tick period is 0,1,0,1,0,0,1,0,1,1, each held exactly 4 clk.
  - frame_done pulses on the 10th tick after grant; busy falls the next cycle.
- All four requesters assert together with 8'h11, 8'h22, 8'h33, 8'h44 -> owner sequence 0,1,2,3.
  - Four contiguous 10-bit frames with no idle high bit between them.
  - Each ack coincides with the previous frame_done tick.
- Fairness: req[0] and req[2] held high continuously -> grants alternate 0,2,0,2. req[1] raised mid-stream is served after the current owner, before the other pending requester by rotation.
- Reset after data bit 3 of a frame from requester 1 -> tx=1 immediately, busy=0.
  - With req[1] and req[3] pending after release, requester 1 is served first, because rr was reset to start at requester 0.
- STOP_BITS=2, DATA_BITS=7: stop level high for 2 tick periods and frame length 10 ticks. A req raised and dropped between ticks produces no ack and no frame.
